// File: rtl/roi_pkg.sv
// Shared types and constants for the ROI scan scheduler and its overlay peers.
package roi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CAPTURE = 3'd2,
    INFER   = 3'd3,
    RECORD  = 3'd4
  } roi_state_t;

  localparam int W_COORD = 12;
  localparam int W_IDX   = 4;
  localparam logic [3:0] DIGIT_TIMEOUT = 4'hF;

  // Linear position index row*nx+col; the largest grid (4x4) tops out at 15.
  function automatic logic [W_IDX-1:0] pos_idx(input logic [1:0] row,
                                               input logic [1:0] col,
                                               input logic [2:0] nx);
    return W_IDX'(row) * W_IDX'(nx) + W_IDX'(col);
  endfunction

endpackage

// File: rtl/roi_scan_ctrl_chk.sv
// Elaboration-time parameter checks for roi_scan_ctrl: grid size and
// coordinate range must fit the 12-bit coordinate datapath.
module roi_scan_ctrl_chk #(
  parameter int X0             = 896,
  parameter int Y0             = 476,
  parameter int STEP           = 64,
  parameter int NX             = 3,
  parameter int NY             = 3,
  parameter int TIMEOUT_FRAMES = 4
) ();

  if (NX < 1 || NX > 4) begin : g_nx_range
    $error("roi_scan_ctrl: NX must be 1..4");
  end

  if (NY < 1 || NY > 4) begin : g_ny_range
    $error("roi_scan_ctrl: NY must be 1..4");
  end

  if (X0 + (NX - 1) * STEP > 4095) begin : g_x_range
    $error("roi_scan_ctrl: X0+(NX-1)*STEP exceeds 4095");
  end

  if (Y0 + (NY - 1) * STEP > 4095) begin : g_y_range
    $error("roi_scan_ctrl: Y0+(NY-1)*STEP exceeds 4095");
  end

  if (TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 7) begin : g_to_range
    $error("roi_scan_ctrl: TIMEOUT_FRAMES must fit the 3-bit frame counter");
  end

endmodule

// File: rtl/roi_scan_ctrl_vsync_edge_det.sv
// Rising-edge detector for vsync in the vo_clk domain; fs is high for the
// single cycle where vsync is 1 and its registered copy is still 0.
module vsync_edge_det (
  input  logic vo_clk,
  input  logic rstn,
  input  logic vsync,
  output logic fs
);

  logic vsync_d_r;

  // Delayed copy of vsync for edge detection.
  always_ff @(posedge vo_clk or negedge rstn) begin
    if (!rstn) begin
      vsync_d_r <= 1'b0;
    end else begin
      vsync_d_r <= vsync;
    end
  end

  assign fs = vsync & ~vsync_d_r;

endmodule

// File: rtl/roi_scan_ctrl.sv
// ROI scan scheduler: steps a 32x32 ROI over an NX x NY grid and sequences
// capture, LeNet inference and result reporting for each position.
module roi_scan_ctrl
  import roi_pkg::*;
#(
  parameter int X0             = 896,
  parameter int Y0             = 476,
  parameter int STEP           = 64,
  parameter int NX             = 3,
  parameter int NY             = 3,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic                vo_clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                vsync,
  input  logic                cap_done,
  input  logic                lenet_ready,
  input  logic [3:0]          lenet_digit,
  output logic [W_COORD-1:0]  roi_x,
  output logic [W_COORD-1:0]  roi_y,
  output logic                cap_arm,
  output logic                lenet_go,
  output logic                res_valid,
  output logic [3:0]          res_digit,
  output logic [W_IDX-1:0]    res_idx,
  output logic                busy,
  output logic                timeout_err
);

  localparam logic [W_COORD-1:0] X0_C   = W_COORD'(X0);
  localparam logic [W_COORD-1:0] Y0_C   = W_COORD'(Y0);
  localparam logic [W_COORD-1:0] STEP_C = W_COORD'(STEP);
  localparam logic [1:0]         NX_M1  = 2'(NX - 1);
  localparam logic [1:0]         NY_M1  = 2'(NY - 1);
  localparam logic [2:0]         NX_C   = 3'(NX);
  localparam logic [2:0]         TO_C   = 3'(TIMEOUT_FRAMES);

  roi_state_t         state_r;
  logic [1:0]         col_r;
  logic [1:0]         row_r;
  logic [2:0]         frame_cnt_r;
  logic [3:0]         digit_r;
  logic               fs_s;
  logic [2:0]         frame_inc_s;
  logic [W_IDX-1:0]   idx_s;

  roi_scan_ctrl_chk #(
    .X0             (X0),
    .Y0             (Y0),
    .STEP           (STEP),
    .NX             (NX),
    .NY             (NY),
    .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
  ) u_chk ();

  vsync_edge_det u_fs (
    .vo_clk (vo_clk),
    .rstn   (rstn),
    .vsync  (vsync),
    .fs     (fs_s)
  );

  assign frame_inc_s = frame_cnt_r + 3'd1;
  assign idx_s       = pos_idx(row_r, col_r, NX_C);

  // Scan FSM with position/frame counters and all registered outputs.
  always_ff @(posedge vo_clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      col_r       <= 2'd0;
      row_r       <= 2'd0;
      frame_cnt_r <= 3'd0;
      digit_r     <= 4'd0;
      roi_x       <= X0_C;
      roi_y       <= Y0_C;
      cap_arm     <= 1'b0;
      lenet_go    <= 1'b0;
      res_valid   <= 1'b0;
      res_digit   <= 4'd0;
      res_idx     <= {W_IDX{1'b0}};
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      lenet_go  <= 1'b0;
      res_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= ARM;
            busy    <= 1'b1;
          end
        end
        // Coordinates move only here, on a frame edge, so they stay
        // constant for the whole frame seen by capture and overlays.
        ARM: begin
          if (fs_s) begin
            roi_x   <= X0_C + W_COORD'(col_r) * STEP_C;
            roi_y   <= Y0_C + W_COORD'(row_r) * STEP_C;
            cap_arm <= 1'b1;
            state_r <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_done) begin
            cap_arm     <= 1'b0;
            lenet_go    <= 1'b1;
            frame_cnt_r <= 3'd0;
            state_r     <= INFER;
          end
        end
        // lenet_ready is tested first so it wins over a coincident timeout.
        INFER: begin
          if (lenet_ready) begin
            digit_r <= lenet_digit;
            state_r <= RECORD;
          end else if (fs_s) begin
            if (frame_inc_s == TO_C) begin
              digit_r     <= DIGIT_TIMEOUT;
              timeout_err <= 1'b1;
              state_r     <= RECORD;
            end else begin
              frame_cnt_r <= frame_inc_s;
            end
          end
        end
        RECORD: begin
          res_valid <= 1'b1;
          res_digit <= digit_r;
          res_idx   <= idx_s;
          if (col_r == NX_M1) begin
            col_r <= 2'd0;
            if (row_r == NY_M1) begin
              row_r <= 2'd0;
            end else begin
              row_r <= row_r + 2'd1;
            end
          end else begin
            col_r <= col_r + 2'd1;
          end
          if (enable) begin
            state_r <= ARM;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cap_arm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roi_scan_ctrl.sv
// Bench for roi_scan_ctrl: a table of scan positions, directed corner cases
// and a randomized phase checked against a position/sticky-error model.
module tb_roi_scan_ctrl;

  localparam int X0   = 896;
  localparam int Y0   = 476;
  localparam int STEP = 64;
  localparam int NX   = 3;
  localparam int NY   = 3;

  logic        vo_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        vsync = 1'b0;
  logic        cap_done = 1'b0;
  logic        lenet_ready = 1'b0;
  logic [3:0]  lenet_digit = 4'd0;
  logic [11:0] roi_x;
  logic [11:0] roi_y;
  logic        cap_arm;
  logic        lenet_go;
  logic        res_valid;
  logic [3:0]  res_digit;
  logic [3:0]  res_idx;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad = 0;
  int go_cnt = 0;
  int exp_go = 0;
  int idx_m = 0;
  bit to_m = 1'b0;
  logic [3:0] q_idx[$];
  logic [3:0] q_dig[$];

  typedef struct {
    logic [3:0]  idx;
    logic [11:0] x;
    logic [11:0] y;
  } vec_t;
  vec_t tbl[10];

  always #5 vo_clk = ~vo_clk;

  roi_scan_ctrl dut (
    .vo_clk      (vo_clk),
    .rstn        (rstn),
    .enable      (enable),
    .vsync       (vsync),
    .cap_done    (cap_done),
    .lenet_ready (lenet_ready),
    .lenet_digit (lenet_digit),
    .roi_x       (roi_x),
    .roi_y       (roi_y),
    .cap_arm     (cap_arm),
    .lenet_go    (lenet_go),
    .res_valid   (res_valid),
    .res_digit   (res_digit),
    .res_idx     (res_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Record every go cycle and every result strobe, away from the active edge.
  always @(negedge vo_clk) begin
    if (lenet_go) go_cnt++;
    if (res_valid) begin
      q_idx.push_back(res_idx);
      q_dig.push_back(res_digit);
    end
  end

  task automatic tick();
    @(posedge vo_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ex_x(input int i);
    return 12'(X0 + (i % NX) * STEP);
  endfunction

  function automatic logic [11:0] ex_y(input int i);
    return 12'(Y0 + (i / NX) * STEP);
  endfunction

  // One scan position: frame edge, capture, n_fs frames in inference, an
  // optional answer, then the result strobe against the model.
  task automatic run_pos(input logic [3:0] e_idx, input logic [11:0] e_x,
                         input logic [11:0] e_y, input int n_fs, input bit answer,
                         input bit same, input int delay, input logic [3:0] dig,
                         input bit stray, input bit drop_en);
    logic [3:0] e_dig;
    bit timed;
    int w;
    repeat ($urandom_range(0, 3)) tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("arm_cap_arm", 32'(cap_arm), 32'd1);
    chk("roi_x", 32'(roi_x), 32'(e_x));
    chk("roi_y", 32'(roi_y), 32'(e_y));
    repeat ($urandom_range(1, 4)) tick();
    if (stray) begin
      lenet_ready = 1'b1;
      lenet_digit = 4'hA;
      tick();
      lenet_ready = 1'b0;
      tick();
      chk("stray_ready_no_res", 32'(q_idx.size()), 32'd0);
      chk("stray_ready_cap_arm", 32'(cap_arm), 32'd1);
    end
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    exp_go++;
    chk("go_pulse", 32'(lenet_go), 32'd1);
    chk("cap_arm_clr", 32'(cap_arm), 32'd0);
    if (stray) cap_done = 1'b1;
    if (drop_en) enable = 1'b0;
    tick();
    cap_done = 1'b0;
    chk("go_width", 32'(lenet_go), 32'd0);
    for (int f = 0; f < n_fs; f++) begin
      vsync = 1'b1;
      if (same && f == n_fs - 1) begin
        lenet_ready = 1'b1;
        lenet_digit = dig;
      end
      tick();
      vsync = 1'b0;
      lenet_ready = 1'b0;
      tick();
    end
    if (answer && !same) begin
      repeat (delay) tick();
      lenet_ready = 1'b1;
      lenet_digit = dig;
      tick();
      lenet_ready = 1'b0;
    end
    timed = !(answer && (same || n_fs < 4));
    e_dig = timed ? 4'hF : dig;
    if (timed) to_m = 1'b1;
    w = 0;
    while (q_idx.size() == 0 && w < 20) begin
      tick();
      w++;
    end
    chk("res_seen", 32'(q_idx.size() > 0), 32'd1);
    if (q_idx.size() > 0) begin
      chk("res_idx", 32'(q_idx.pop_front()), 32'(e_idx));
      chk("res_digit", 32'(q_dig.pop_front()), 32'(e_dig));
    end
    chk("timeout_err", 32'(timeout_err), 32'(to_m));
    tick();
    chk("res_single", 32'(q_idx.size()), 32'd0);
    chk("go_count", 32'(go_cnt), 32'(exp_go));
    idx_m = (int'(e_idx) + 1) % (NX * NY);
  endtask

  initial begin
    int n;
    bit same;
    bit answer;
    for (int i = 0; i < 9; i++) begin
      tbl[i].idx = 4'(i);
    end
    tbl[0].x = 12'd896;  tbl[0].y = 12'd476;
    tbl[1].x = 12'd960;  tbl[1].y = 12'd476;
    tbl[2].x = 12'd1024; tbl[2].y = 12'd476;
    tbl[3].x = 12'd896;  tbl[3].y = 12'd540;
    tbl[4].x = 12'd960;  tbl[4].y = 12'd540;
    tbl[5].x = 12'd1024; tbl[5].y = 12'd540;
    tbl[6].x = 12'd896;  tbl[6].y = 12'd604;
    tbl[7].x = 12'd960;  tbl[7].y = 12'd604;
    tbl[8].x = 12'd1024; tbl[8].y = 12'd604;
    tbl[9].idx = 4'd0; tbl[9].x = 12'd896; tbl[9].y = 12'd476;

    repeat (3) tick();
    chk("rst_roi_x", 32'(roi_x), 32'd896);
    chk("rst_roi_y", 32'(roi_y), 32'd476);
    chk("rst_cap_arm", 32'(cap_arm), 32'd0);
    chk("rst_lenet_go", 32'(lenet_go), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_digit", 32'(res_digit), 32'd0);
    chk("rst_res_idx", 32'(res_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rstn = 1'b1;
    tick();

    // Disabled: frames and stray cap_done leave the block idle.
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    cap_done = 1'b1; tick(); cap_done = 1'b0; tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cap_arm", 32'(cap_arm), 32'd0);
    chk("idle_stray_go", 32'(go_cnt), 32'd0);
    enable = 1'b1;
    tick();
    chk("enable_busy", 32'(busy), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_pos(tbl[i].idx, tbl[i].x, tbl[i].y, 0, 1'b1, 1'b0, 100, tbl[i].idx, 1'b0, 1'b0);
    end

    // Ready on the same cycle as the 4th frame edge: the real digit wins.
    run_pos(4'(idx_m), ex_x(idx_m), ex_y(idx_m), 4, 1'b1, 1'b1, 0, 4'd7, 1'b0, 1'b0);
    run_pos(4'(idx_m), ex_x(idx_m), ex_y(idx_m), 4, 1'b0, 1'b0, 0, 4'd0, 1'b0, 1'b0);
    run_pos(4'(idx_m), ex_x(idx_m), ex_y(idx_m), 1, 1'b1, 1'b0, 20, 4'd3, 1'b1, 1'b0);
    run_pos(4'(idx_m), ex_x(idx_m), ex_y(idx_m), 0, 1'b1, 1'b0, 30, 4'd9, 1'b0, 1'b1);
    chk("drop_busy", 32'(busy), 32'd0);
    repeat (2) begin
      vsync = 1'b1; tick(); vsync = 1'b0; tick();
    end
    chk("drop_roi_x", 32'(roi_x), 32'd960);
    chk("drop_roi_y", 32'(roi_y), 32'd540);
    chk("drop_cap_arm", 32'(cap_arm), 32'd0);
    chk("drop_busy_hold", 32'(busy), 32'd0);
    chk("drop_no_res", 32'(q_idx.size()), 32'd0);
    enable = 1'b1;
    tick();
    chk("resume_busy", 32'(busy), 32'd1);
    run_pos(4'(idx_m), ex_x(idx_m), ex_y(idx_m), 2, 1'b1, 1'b0, 10, 4'd5, 1'b0, 1'b0);

    // Asynchronous reset while waiting for cap_done.
    tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("pre_rst_cap_arm", 32'(cap_arm), 32'd1);
    chk("pre_rst_roi_y", 32'(roi_y), 32'(ex_y(idx_m)));
    rstn = 1'b0;
    #1;
    chk("arst_cap_arm", 32'(cap_arm), 32'd0);
    chk("arst_roi_x", 32'(roi_x), 32'd896);
    chk("arst_roi_y", 32'(roi_y), 32'd476);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_timeout_err", 32'(timeout_err), 32'd0);
    chk("arst_res_idx", 32'(res_idx), 32'd0);
    chk("arst_res_digit", 32'(res_digit), 32'd0);
    chk("arst_go", 32'(lenet_go), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    tick();
    rstn = 1'b1;
    lenet_ready = 1'b1;
    lenet_digit = 4'd6;
    tick();
    lenet_ready = 1'b0;
    repeat (3) tick();
    chk("post_rst_no_res", 32'(q_idx.size()), 32'd0);
    chk("post_rst_go", 32'(go_cnt), 32'(exp_go));
    chk("post_rst_busy", 32'(busy), 32'd1);
    idx_m = 0;
    to_m = 1'b0;

    for (int k = 0; k < 14; k++) begin
      n = int'($urandom_range(0, 4));
      same = (n > 0) ? bit'($urandom_range(0, 1)) : 1'b0;
      answer = (n < 4) || same;
      run_pos(4'(idx_m), ex_x(idx_m), ex_y(idx_m), n, answer, same,
              int'($urandom_range(1, 40)), 4'($urandom_range(0, 9)),
              bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
